// File: rtl/ysyx_23060203_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_pkg
// Definitions shared by the fetch stage and by decode:
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - OP_*             : major opcodes, inst[6:2]
//   - fetch_state_e    : fetch FSM states
//   - imm_b()          : sign-extended B-type immediate (bit0 = 0)
// ---------------------------------------------------------------------------
package ysyx_23060203_ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

    // Major opcodes, inst[6:2]. Decode uses the same table.
    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    // IDLE: nothing outstanding; REQ: request on the bus; WAIT: response pending.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_23060203_ifu_spred.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_spred
// Static next-pc predictor. Conditional branches with a negative offset
// (inst[31]=1) are predicted taken; everything else, including JAL/JALR,
// falls through to pc+4. Decode re-checks with the same rule.
// Ports:
//   pc       in  32  pc of the instruction
//   inst     in  32  instruction word
//   pred_npc out 32  predicted next fetch address
// ---------------------------------------------------------------------------
module ysyx_23060203_ifu_spred
    import ysyx_23060203_ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] pred_npc
);

    logic taken;
    logic unused_bits;

    assign taken       = (inst[6:2] == OP_BRANCH) && inst[31];
    assign pred_npc    = taken ? (pc + imm_b(inst)) : (pc + 32'd4);
    assign unused_bits = ^{inst[24:12], inst[1:0]};

endmodule

// File: rtl/ysyx_23060203_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu
// Instruction fetch stage. Issues one fetch at a time on the instruction
// memory bus, holds the returned instruction in a one-entry buffer and
// offers it to decode. Redirects from the back end (flush) or from decode
// (jump_flush) retarget fetch; an in-flight wrong-path transaction is
// allowed to finish and its response is dropped.
//
// Handshakes (both interfaces): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once imem_req_valid is raised, it and
// imem_req_addr stay unchanged until the transfer. The memory response is
// a one-cycle imem_resp_valid pulse that is always accepted.
//
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   flush, flush_pc        back-end redirect and target (highest priority)
//   jump_flush, jump_dnpc  decode redirect and target
//   imem_req_*             fetch request (valid/ready/addr)
//   imem_resp_*            fetch response (valid/data)
//   out_valid/out_ready    instruction handshake towards decode
//   out_pc, out_inst       offered instruction
//   dbg_state              current fetch FSM state
// ---------------------------------------------------------------------------
module ysyx_23060203_ifu
    import ysyx_23060203_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    input  logic         jump_flush,
    input  logic [31:0]  jump_dnpc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_inst,
    output fetch_state_e dbg_state
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_addr;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_inst;
    logic         drop;

    logic         redirect;
    logic [31:0]  redirect_raw;
    logic [31:0]  redirect_pc;
    logic         fire;
    logic         still_pending;
    logic [31:0]  pred_npc;
    logic         unused_bits;

    assign redirect     = flush | jump_flush;
    assign redirect_raw = flush ? flush_pc : jump_dnpc;
    assign redirect_pc  = {redirect_raw[31:1], 1'b0};
    assign unused_bits  = redirect_raw[0];

    // Never hand over a buffered (now wrong-path) instruction in a redirect cycle.
    assign out_valid = buf_valid & ~flush & ~jump_flush;
    assign fire      = out_valid & out_ready;

    // A transaction that is still open after this edge needs its response dropped.
    // A response arriving now closes the transaction, so no drop is armed for it.
    assign still_pending = (state == REQ) || ((state == WAIT) && !imem_resp_valid);

    ysyx_23060203_ifu_spred u_spred (
        .pc       (fetch_pc),
        .inst     (imem_resp_data),
        .pred_npc (pred_npc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= '0;
            drop      <= 1'b0;
        end else begin
            if (fire) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Issue only when the buffer will have room after this edge.
                    if (!redirect && (!buf_valid || fire)) begin
                        state    <= REQ;
                        req_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        // fetch_pc still equals the issued address when drop=0.
                        if (!drop && !redirect) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= fetch_pc;
                            buf_inst  <= imem_resp_data;
                            fetch_pc  <= pred_npc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Redirect overrides buffer and pc updates above; the bus
            // transaction itself (state, req_addr) is left to complete.
            if (redirect) begin
                buf_valid <= 1'b0;
                fetch_pc  <= redirect_pc;
                if (still_pending) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = req_addr;
    assign out_pc         = buf_pc;
    assign out_inst       = buf_inst;
    assign dbg_state      = state;

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
module tb_ysyx_23060203_ifu;
    import ysyx_23060203_ifu_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [31:0]  flush_pc = '0;
    logic         jump_flush = 1'b0;
    logic [31:0]  jump_dnpc = '0;
    logic         imem_req_valid;
    logic         imem_req_ready = 1'b0;
    logic [31:0]  imem_req_addr;
    logic         imem_resp_valid = 1'b0;
    logic [31:0]  imem_resp_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_pc;
    logic [31:0]  out_inst;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [logic [31:0]];
    bit          hash_mem = 1'b0;
    int          mem_lat_min = 1;
    int          mem_lat_max = 1;

    ysyx_23060203_ifu dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .jump_flush      (jump_flush),
        .jump_dnpc       (jump_dnpc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .dbg_state       (dbg_state)
    );

    always #5 clock = ~clock;

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] h;
        if (prog.exists(a)) return prog[a];
        if (!hash_mem) return NOP;
        h = (a ^ (a >> 7)) * 32'h2545_F491;
        h = h ^ (h >> 13);
        // Branch immediates keep bit1 clear so every target stays word-aligned.
        if (h[3:0] < 4'd3) return {h[31:9], 1'b0, h[7], 7'b1100011};
        return {h[31:7], 7'b0010011};
    endfunction

    // Reference next-pc: taken backward conditional branches, else pc+4.
    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] off;
        if (inst[6:2] == 5'b11000 && inst[31]) begin
            off = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            return pc + off;
        end
        return pc + 32'd4;
    endfunction

    // ---------------- memory responder ----------------
    initial begin : mem_responder
        logic        acc;
        logic [31:0] a;
        int          lat;
        forever begin
            @(negedge clock);
            acc = imem_req_valid && imem_req_ready && !reset;
            a   = imem_req_addr;
            @(posedge clock);
            #1;
            if (acc) begin
                lat = $urandom_range(mem_lat_min, mem_lat_max);
                repeat (lat - 1) begin
                    @(posedge clock);
                    #1;
                end
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_read(a);
                @(posedge clock);
                #1;
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset(input int lat_min, input int lat_max);
        reset = 1'b1;
        flush = 1'b0;
        jump_flush = 1'b0;
        out_ready = 1'b0;
        imem_req_ready = 1'b0;
        mem_lat_min = lat_min;
        mem_lat_max = lat_max;
        repeat (5) step();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b expected 0", imem_req_valid);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req[$];
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int first;
        prog.delete();
        hash_mem = 1'b0;
        do_reset(1, 1);
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        exp_req = {BASE, BASE + 32'd4, BASE + 32'd8};
        exp_q   = {BASE, BASE + 32'd4, BASE + 32'd8};
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (out_valid && first < 0) first = i;
            if (imem_req_valid && imem_req_ready && exp_req.size() > 0) begin
                e = exp_req.pop_front();
                checks++;
                if (imem_req_addr !== e) begin
                    errors++;
                    $display("FAIL seq_req_addr got %h expected %h", imem_req_addr, e);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_pc !== e || out_inst !== mem_read(e)) begin
                    errors++;
                    $display("FAIL seq_out got pc %h inst %h expected pc %h inst %h",
                             out_pc, out_inst, e, mem_read(e));
                end
            end
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL seq_first_latency got %0d expected 3", first);
        end
        checks++;
        if (exp_req.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL seq_complete got %0d/%0d left expected 0/0", exp_req.size(), exp_q.size());
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_next;
        bit saw, found;
        for (int v = 0; v < 2; v++) begin
            prog.delete();
            hash_mem = 1'b0;
            prog[BASE + 32'h10] = (v == 0) ? 32'hFE00_0EE3 : 32'h0000_0463;
            exp_next = (v == 0) ? BASE + 32'h0C : BASE + 32'h14;
            do_reset(1, 1);
            out_ready = 1'b1;
            imem_req_ready = 1'b1;
            saw = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                step();
                if (imem_req_valid && imem_req_ready) begin
                    if (saw) begin
                        found = 1'b1;
                        checks++;
                        if (imem_req_addr !== exp_next) begin
                            errors++;
                            $display("FAIL branch_next_%0d got %h expected %h", v, imem_req_addr, exp_next);
                        end
                    end
                    if (imem_req_addr == BASE + 32'h10) saw = 1'b1;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL branch_timeout_%0d got none expected %h", v, exp_next);
            end
        end
    endtask

    task automatic test_jump_flush();
        bit hit, got, req_seen;
        prog.delete();
        hash_mem = 1'b0;
        do_reset(2, 2);
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            step();
            if (imem_req_valid && imem_req_ready && imem_req_addr == BASE + 32'h20) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL jf_reach got none expected request %h", BASE + 32'h20);
            return;
        end
        step();
        checks++;
        if (dbg_state !== WAIT || imem_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL jf_wait got state %0d resp %b expected %0d 0", dbg_state, imem_resp_valid, WAIT);
        end
        jump_flush = 1'b1;
        jump_dnpc = BASE + 32'h100;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL jf_out_valid got %b expected 0", out_valid);
        end
        step();
        jump_flush = 1'b0;
        got = 1'b0;
        req_seen = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req_valid && imem_req_ready && !req_seen) begin
                req_seen = 1'b1;
                checks++;
                if (imem_req_addr !== BASE + 32'h100) begin
                    errors++;
                    $display("FAIL jf_req got %h expected %h", imem_req_addr, BASE + 32'h100);
                end
            end
            if (out_valid) begin
                got = 1'b1;
                checks++;
                if (out_pc !== BASE + 32'h100) begin
                    errors++;
                    $display("FAIL jf_first_out got %h expected %h", out_pc, BASE + 32'h100);
                end
            end
            step();
        end
        checks++;
        if (!got || !req_seen) begin
            errors++;
            $display("FAIL jf_timeout got out %b req %b expected 1 1", got, req_seen);
        end
    endtask

    task automatic test_dual_flush();
        bit hit, got, req_seen;
        prog.delete();
        hash_mem = 1'b0;
        do_reset(1, 1);
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (out_valid) hit = 1'b1;
        end
        checks++;
        if (!hit || out_pc !== BASE) begin
            errors++;
            $display("FAIL df_fill got valid %b pc %h expected 1 %h", hit, out_pc, BASE);
        end
        flush = 1'b1;
        flush_pc = BASE + 32'h200;
        jump_flush = 1'b1;
        jump_dnpc = BASE + 32'h100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL df_redirect_cycle got %b expected 0", out_valid);
        end
        step();
        flush = 1'b0;
        jump_flush = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL df_cleared got out %b req %b expected 0 0", out_valid, imem_req_valid);
        end
        got = 1'b0;
        req_seen = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (imem_req_valid && imem_req_ready && !req_seen) begin
                req_seen = 1'b1;
                checks++;
                if (imem_req_addr !== BASE + 32'h200) begin
                    errors++;
                    $display("FAIL df_req got %h expected %h", imem_req_addr, BASE + 32'h200);
                end
            end
            if (out_valid) begin
                got = 1'b1;
                checks++;
                if (out_pc !== BASE + 32'h200) begin
                    errors++;
                    $display("FAIL df_first_out got %h expected %h", out_pc, BASE + 32'h200);
                end
            end
        end
        checks++;
        if (!got || !req_seen) begin
            errors++;
            $display("FAIL df_timeout got out %b req %b expected 1 1", got, req_seen);
        end
    endtask

    task automatic test_stall();
        bit hit;
        prog.delete();
        hash_mem = 1'b0;
        prog[BASE] = 32'h00A0_0093;
        do_reset(1, 1);
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (out_valid) hit = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || imem_req_valid !== 1'b0 ||
                out_pc !== BASE || out_inst !== 32'h00A0_0093) begin
                errors++;
                $display("FAIL stall_hold_%0d got v %b req %b pc %h inst %h expected 1 0 %h %h",
                         i, out_valid, imem_req_valid, out_pc, out_inst, BASE, 32'h00A0_0093);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE + 32'd4 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got req %b addr %h out %b expected 1 %h 0",
                     imem_req_valid, imem_req_addr, out_valid, BASE + 32'd4);
        end
    endtask

    task automatic test_req_stall();
        int n_acc;
        bit got;
        prog.delete();
        hash_mem = 1'b0;
        do_reset(1, 1);
        imem_req_ready = 1'b0;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE) begin
                errors++;
                $display("FAIL rs_hold_%0d got %b %h expected 1 %h", i, imem_req_valid, imem_req_addr, BASE);
            end
            step();
        end
        jump_flush = 1'b1;
        jump_dnpc = BASE + 32'h300;
        step();
        jump_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE) begin
                errors++;
                $display("FAIL rs_hold_after_%0d got %b %h expected 1 %h", i, imem_req_valid, imem_req_addr, BASE);
            end
            step();
        end
        imem_req_ready = 1'b1;
        n_acc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req_valid && imem_req_ready && n_acc < 2) begin
                checks++;
                if (imem_req_addr !== ((n_acc == 0) ? BASE : BASE + 32'h300)) begin
                    errors++;
                    $display("FAIL rs_accept_%0d got %h expected %h", n_acc, imem_req_addr,
                             (n_acc == 0) ? BASE : BASE + 32'h300);
                end
                n_acc++;
            end
            if (out_valid) begin
                got = 1'b1;
                checks++;
                if (out_pc !== BASE + 32'h300) begin
                    errors++;
                    $display("FAIL rs_first_out got %h expected %h", out_pc, BASE + 32'h300);
                end
            end
            step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rs_timeout got no output expected pc %h", BASE + 32'h300);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        bit prev_stall;
        int r, n_out;
        prog.delete();
        hash_mem = 1'b1;
        do_reset(1, 3);
        exp_pc = BASE;
        prev_stall = 1'b0;
        prev_addr = '0;
        n_out = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 31);
            flush = (r == 0) || (r == 2);
            jump_flush = (r == 1) || (r == 2);
            flush_pc = BASE + ($urandom_range(0, 1023) << 2);
            jump_dnpc = BASE + ($urandom_range(0, 1023) << 2);
            #1;
            if (prev_stall) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_req_stable cyc %0d got %b %h expected 1 %h",
                             cyc, imem_req_valid, imem_req_addr, prev_addr);
                end
            end
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr[1:0] !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_req_align cyc %0d got %h expected low bits 00", cyc, imem_req_addr);
                end
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
            if (flush || jump_flush) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_redirect_out cyc %0d got %b expected 0", cyc, out_valid);
                end
                exp_pc = flush ? {flush_pc[31:1], 1'b0} : {jump_dnpc[31:1], 1'b0};
            end else if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_inst !== mem_read(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_out cyc %0d got pc %h inst %h expected pc %h inst %h",
                             cyc, out_pc, out_inst, exp_pc, mem_read(exp_pc));
                end
                n_out++;
                exp_pc = model_npc(exp_pc, mem_read(exp_pc));
            end
        end
        flush = 1'b0;
        jump_flush = 1'b0;
        checks++;
        if (n_out < 100) begin
            errors++;
            $display("FAIL rnd_progress got %0d outputs expected at least 100", n_out);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_flush();
        test_dual_flush();
        test_stall();
        test_req_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
